multi_clock_divider: RTL and testbench

//  N-channel programmable clock divider. Each channel has a runtime-set period and high time.

---
 rtl/multi_clock_divider.sv | 95 +++++++++
 tb/tb_multi_clock_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider: registered divided clocks, rising-edge ticks,
// and double-buffered period/high-time that take effect only at a safe apply point.
module multi_clock_divider #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 2
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [3:0]       i_wr_ch,
    input  logic [CNT_W-1:0] i_wr_div,
    input  logic [CNT_W-1:0] i_wr_high,
    input  logic [N_CH-1:0]  i_en,
    input  logic             i_sync,
    output logic [N_CH-1:0]  o_clk_out,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_pend
);

    localparam logic [CNT_W-1:0] P_RST = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] H_RST = CNT_W'(DEF_DIV / 2);
    localparam logic [CNT_W-1:0] P_MIN = CNT_W'(2);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_act_p;
        logic [CNT_W-1:0] r_act_h;
        logic [CNT_W-1:0] r_pnd_p;
        logic [CNT_W-1:0] r_pnd_h;
        logic             r_pend;
        logic             r_run;
        logic             r_clk;
        logic             r_tick;

        logic             w_idle;
        logic             w_wr_hit;
        logic             w_wrap;
        logic             w_apply;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_p_nxt;
        logic [CNT_W-1:0] w_h_nxt;
        logic             w_clk_nxt;

        // Out-of-range channel indices never match, so those writes vanish.
        assign w_wr_hit = i_wr_en && (i_wr_ch == 4'(g));
        assign w_idle   = !i_en[g] || (r_act_p < P_MIN);
        assign w_wrap   = (r_cnt == r_act_p - 1'b1);
        assign w_apply  = w_idle || i_sync || w_wrap;

        // Restart at phase 0 on the first running cycle, on sync, and at wrap.
        always_comb begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_idle || !r_run || i_sync || w_wrap) begin
                w_cnt_nxt = '0;
            end
            w_p_nxt   = w_apply ? r_pnd_p : r_act_p;
            w_h_nxt   = w_apply ? r_pnd_h : r_act_h;
            w_clk_nxt = !w_idle && (w_p_nxt >= P_MIN) && (w_cnt_nxt < w_h_nxt);
        end

        always_ff @(posedge i_clk_in or negedge i_rst) begin
            if (!i_rst) begin
                r_cnt   <= '0;
                r_act_p <= P_RST;
                r_act_h <= H_RST;
                r_pnd_p <= P_RST;
                r_pnd_h <= H_RST;
                r_pend  <= 1'b0;
                r_run   <= 1'b0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_act_p <= w_p_nxt;
                r_act_h <= w_h_nxt;
                r_run   <= !w_idle;
                r_clk   <= w_clk_nxt;
                r_tick  <= w_clk_nxt && !r_clk;
                if (w_wr_hit) begin
                    r_pnd_p <= i_wr_div;
                    r_pnd_h <= i_wr_high;
                    r_pend  <= 1'b1;
                end else if (w_apply) begin
                    r_pend  <= 1'b0;
                end
            end
        end

        assign o_clk_out[g] = r_clk;
        assign o_tick[g]    = r_tick;
        assign o_pend[g]    = r_pend;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomized + directed bench for multi_clock_divider against a phase-position reference model.
module tb_multi_clock_divider;

    localparam int N  = 4;
    localparam int CW = 16;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [3:0]    wr_ch;
    logic [CW-1:0] wr_div;
    logic [CW-1:0] wr_high;
    logic [N-1:0]  en;
    logic          sync;
    logic [N-1:0]  clk_out;
    logic [N-1:0]  tick;
    logic [N-1:0]  pend;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: active/pending P,H, position within period, outputs.
    int m_p[N], m_h[N], m_pp[N], m_ph[N], m_pos[N];
    bit m_on[N], m_pend[N], m_clk[N], m_tick[N];

    multi_clock_divider #(.N_CH(N), .CNT_W(CW), .DEF_DIV(2)) dut (
        .i_clk_in  (clk_in),
        .i_rst     (rst),
        .i_wr_en   (wr_en),
        .i_wr_ch   (wr_ch),
        .i_wr_div  (wr_div),
        .i_wr_high (wr_high),
        .i_en      (en),
        .i_sync    (sync),
        .o_clk_out (clk_out),
        .o_tick    (tick),
        .o_pend    (pend)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_p[c] = 2;  m_h[c] = 1;  m_pp[c] = 2;  m_ph[c] = 1;
            m_pos[c] = 0; m_on[c] = 0; m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit hit, apply, idle, prev;
            hit   = wr_en && (int'(wr_ch) == c);
            prev  = m_clk[c];
            idle  = !en[c] || (m_p[c] < 2);
            apply = 0;
            if (idle) begin
                apply = 1; m_on[c] = 0; m_pos[c] = 0;
            end else if (!m_on[c] || sync) begin
                apply = sync; m_on[c] = 1; m_pos[c] = 0;
            end else begin
                m_pos[c] = (m_pos[c] + 1) % m_p[c];
                apply    = (m_pos[c] == 0);
            end
            if (apply) begin
                m_p[c] = m_pp[c];
                m_h[c] = m_ph[c];
            end
            m_clk[c]  = !idle && (m_p[c] >= 2) && (m_pos[c] < m_h[c]);
            m_tick[c] = m_clk[c] && !prev;
            if (hit) begin
                m_pend[c] = 1; m_pp[c] = int'(wr_div); m_ph[c] = int'(wr_high);
            end else if (apply) begin
                m_pend[c] = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] vec_clk();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = m_clk[c];
        return v;
    endfunction

    function automatic logic [N-1:0] vec_tick();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = m_tick[c];
        return v;
    endfunction

    function automatic logic [N-1:0] vec_pend();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = m_pend[c];
        return v;
    endfunction

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc(input string tag);
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        check({tag, ".clk"},  32'(clk_out), 32'(vec_clk()));
        check({tag, ".tick"}, 32'(tick),    32'(vec_tick()));
        check({tag, ".pend"}, 32'(pend),    32'(vec_pend()));
        wr_en = 1'b0;
        sync  = 1'b0;
    endtask

    task automatic write(input int ch, input int p, input int h);
        wr_en = 1'b1; wr_ch = 4'(ch); wr_div = CW'(p); wr_high = CW'(h);
    endtask

    logic [N-1:0] pend_before;
    logic [N-1:0] ch1_seq;

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_high = '0; en = '0; sync = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        check("rst.clk",  32'(clk_out), 32'h0);
        check("rst.tick", 32'(tick),    32'h0);
        check("rst.pend", 32'(pend),    32'h0);
        rst = 1'b1;

        // Default P=2,H=1: every channel toggles each cycle after enable.
        en = 4'b1111;
        cyc("def0");
        check("def.first_rise", 32'(clk_out), 32'hF);
        cyc("def1");
        check("def.low", 32'(clk_out), 32'h0);
        for (int i = 0; i < 4; i++) cyc("def");

        // ch1 P=5 H=2 -> 11000 repeating.
        en = 4'b0000;
        write(1, 5, 2);
        cyc("w1");
        cyc("w1b");
        en = 4'b0010;
        ch1_seq = '0;
        for (int i = 0; i < 10; i++) begin
            cyc("ch1");
            if (i < 4) ch1_seq[3-i] = clk_out[1];
        end
        check("ch1.pattern", 32'(ch1_seq), 32'hC);

        // Mid-period write: old period completes, then 100 pattern.
        cyc("ch1c0");
        cyc("ch1c1");
        write(1, 3, 1);
        cyc("mid");
        check("mid.pend", 32'(pend[1]), 32'h1);
        for (int i = 0; i < 9; i++) cyc("ch1p3");

        // ch2 H=0, then H>=P, then P=1.
        en = 4'b0100;
        write(2, 4, 0);
        for (int i = 0; i < 6; i++) cyc("h0");
        check("h0.low", 32'(clk_out[2]), 32'h0);
        write(2, 4, 7);
        for (int i = 0; i < 8; i++) cyc("hbig");
        check("hbig.high", 32'(clk_out[2]), 32'h1);
        write(2, 1, 1);
        for (int i = 0; i < 6; i++) cyc("p1");
        check("p1.idle", 32'(clk_out[2]), 32'h0);

        // ch0 P=4, ch3 P=6, then sync realigns.
        en = 4'b0000;
        write(0, 4, 2); cyc("s0");
        write(3, 6, 3); cyc("s1");
        en = 4'b1001;
        for (int i = 0; i < 7; i++) cyc("pre_sync");
        sync = 1'b1;
        cyc("sync");
        check("sync.both_high", 32'({clk_out[3], clk_out[0]}), 32'h3);
        for (int i = 0; i < 8; i++) cyc("post_sync");

        // Ignored out-of-range channel write.
        pend_before = pend;
        write(9, 7, 3);
        cyc("wch9");
        check("wch9.pend", 32'(pend), 32'(pend_before));

        // Asynchronous reset during high phase, between clock edges.
        en = 4'b0001;
        write(0, 8, 6); cyc("ar0");
        for (int i = 0; i < 10; i++) cyc("ar1");
        #2 rst = 1'b0;
        #1;
        check("arst.clk",  32'(clk_out), 32'h0);
        check("arst.tick", 32'(tick),    32'h0);
        check("arst.pend", 32'(pend),    32'h0);
        model_reset();
        en = 4'b0000;
        @(negedge clk_in);
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                write(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
            if ($urandom_range(0, 9) == 0) en = 4'($urandom_range(0, 15));
            sync = ($urandom_range(0, 19) == 0);
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
